// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the programmable serial pattern detector.
// Holds the run-controller state encoding and the default widths used by
// the interface, the controller and the shift/match datapath.
package seq_detect_pkg;

  localparam int unsigned PAT_W_DEF = 4;  // pattern length in bits (2..8)
  localparam int unsigned LEN_W_DEF = 8;  // run-length budget width
  localparam int unsigned CNT_W_DEF = 8;  // match counter width

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Command/stream/result bundle of the serial pattern detector.
//   start, pattern, length : run request and its captured parameters
//   x_valid, x             : qualified serial input bit
//   busy, done, match      : run status and registered event pulses
//   match_count, bits_seen : per-run statistics, held until the next start
// master = stimulus/result side, slave = detector.
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic             x_valid;
  logic             x;
  logic             busy;
  logic             done;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic [LEN_W-1:0] bits_seen;

  modport master (
    output start, pattern, length, x_valid, x,
    input  busy, done, match, match_count, bits_seen
  );

  modport slave (
    input  start, pattern, length, x_valid, x,
    output busy, done, match, match_count, bits_seen
  );

endinterface

// File: rtl/seq_detect_ctrl_pattern_shift_match.sv
// History shift register, fill counter and pattern compare.
//   clk, reset  : clock, async active-low reset
//   capture     : load pattern_in and clear history/fill (accepted start)
//   pattern_in  : pattern to capture, MSB = oldest bit
//   shift_en    : accept x this cycle
//   x           : serial bit
//   hit_c       : combinational compare of the bit currently on x
//   match       : registered hit, high the cycle after the completing bit
module pattern_shift_match
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             shift_en,
  input  logic             x,
  output logic             hit_c,
  output logic             match
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  // Only the PAT_W-1 most recent bits are kept; the incoming bit completes the window.
  logic [PAT_W-2:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  window_c;

  // Window as it would be after accepting x; the fill guard stops a reset-zero
  // history from matching before PAT_W real bits have arrived.
  always_comb begin
    window_c = {hist_q, x};
    hit_c    = (window_c == pat_q) && (fill_q >= FILL_W'(PAT_W - 1));
  end

  // History/fill update; match is not cleared on a hit so overlaps are seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      match  <= 1'b0;
    end else if (capture) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= pattern_in;
      match  <= 1'b0;
    end else begin
      match <= shift_en && hit_c;
      if (shift_en) begin
        hist_q <= window_c[PAT_W-2:0];
        if (fill_q != FILL_W'(PAT_W)) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the programmable serial pattern detector.
//   clk, reset : clock, async active-low reset
//   bus        : slave side of seq_detect_ctrl_if (command, stream, results)
// IDLE waits for start, RUN consumes `length` valid bits while counting
// (saturating) overlapping matches, DONE pulses done for one cycle.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  seq_detect_ctrl_if.slave   bus
);

  state_e           state_q;
  state_e           state_d;
  logic [LEN_W-1:0] len_q;
  logic             capture_c;
  logic             accept_c;
  logic             last_bit_c;
  logic             hit_c;
  logic             busy_d;
  logic             done_d;

  pattern_shift_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk        (clk),
    .reset      (reset),
    .capture    (capture_c),
    .pattern_in (bus.pattern),
    .shift_en   (accept_c),
    .x          (bus.x),
    .hit_c      (hit_c),
    .match      (bus.match)
  );

  // Bit-acceptance qualifiers; bits_seen never exceeds len_q so +1 cannot wrap.
  always_comb begin
    accept_c   = (state_q == RUN) && bus.x_valid;
    last_bit_c = accept_c && ((bus.bits_seen + 1'b1) == len_q);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture_c = 1'b1;
          state_d   = (bus.length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_bit_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State register with registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.busy <= busy_d;
      bus.done <= done_d;
    end
  end

  // Captured length, consumed-bit count and saturating match counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q           <= '0;
      bus.bits_seen   <= '0;
      bus.match_count <= '0;
    end else if (capture_c) begin
      len_q           <= bus.length;
      bus.bits_seen   <= '0;
      bus.match_count <= '0;
    end else if (accept_c) begin
      bus.bits_seen <= bus.bits_seen + 1'b1;
      if (hit_c && (bus.match_count != {CNT_W{1'b1}})) begin
        bus.match_count <= bus.match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl. Two instances share one stimulus:
// u_dut8 (CNT_W=8) carries most checks, u_dut4 (CNT_W=4) shows saturation.
// Inputs change 1 ns after posedge; outputs are sampled there as well.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] length;
  logic       x_valid;
  logic       x;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.PAT_W(4), .LEN_W(8), .CNT_W(8)) bus8 ();
  seq_detect_ctrl_if #(.PAT_W(4), .LEN_W(8), .CNT_W(4)) bus4 ();

  assign bus8.start   = start;
  assign bus8.pattern = pattern;
  assign bus8.length  = length;
  assign bus8.x_valid = x_valid;
  assign bus8.x       = x;
  assign bus4.start   = start;
  assign bus4.pattern = pattern;
  assign bus4.length  = length;
  assign bus4.x_valid = x_valid;
  assign bus4.x       = x;

  seq_detect_ctrl #(.PAT_W(4), .LEN_W(8), .CNT_W(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  seq_detect_ctrl #(.PAT_W(4), .LEN_W(8), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] pat, input logic [7:0] len);
    pattern = pat;
    length  = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    x_valid = 1'b1;
    x       = b;
    tick();
    x_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] s1_bits;
    logic [6:0] s1_exp;
    logic [3:0] s3_bits;
    logic [4:0] s6_bits;
    logic [4:0] s6_exp;

    reset   = 1'b0;
    start   = 1'b0;
    pattern = '0;
    length  = '0;
    x_valid = 1'b0;
    x       = 1'b0;
    repeat (2) tick();
    check("rst_busy",  32'(bus8.busy), 0);
    check("rst_done",  32'(bus8.done), 0);
    check("rst_match", 32'(bus8.match), 0);
    check("rst_count", 32'(bus8.match_count), 0);
    check("rst_bits",  32'(bus8.bits_seen), 0);
    reset = 1'b1;
    tick();

    // 1001 over 1,0,0,1,0,0,1: overlapping matches after bits 4 and 7
    do_start(4'b1001, 8'd7);
    pattern = 4'b0000;
    length  = 8'd2;
    check("t1_busy", 32'(bus8.busy), 1);
    s1_bits = 7'b1001001;
    s1_exp  = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      send_bit(s1_bits[i]);
      check("t1_match", 32'(bus8.match), 32'(s1_exp[i]));
      if (i == 3) check("t1_count_mid", 32'(bus8.match_count), 1);
      if (i > 0) check("t1_done_early", 32'(bus8.done), 0);
    end
    check("t1_done",  32'(bus8.done), 1);
    check("t1_busy_end", 32'(bus8.busy), 0);
    check("t1_count", 32'(bus8.match_count), 2);
    check("t1_bits",  32'(bus8.bits_seen), 7);
    tick();
    check("t1_done_one", 32'(bus8.done), 0);
    check("t1_hold_count", 32'(bus8.match_count), 2);

    // 0000 over three zeros: fill guard blocks the match
    do_start(4'b0000, 8'd3);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0);
      check("t2_match", 32'(bus8.match), 0);
    end
    check("t2_done",  32'(bus8.done), 1);
    check("t2_count", 32'(bus8.match_count), 0);
    check("t2_bits",  32'(bus8.bits_seen), 3);
    tick();

    // 1001 with 3-cycle gaps; input changes after start are ignored
    do_start(4'b1001, 8'd4);
    pattern = 4'b0110;
    length  = 8'd1;
    s3_bits = 4'b1001;
    for (int i = 3; i >= 0; i--) begin
      send_bit(s3_bits[i]);
      check("t3_match", 32'(bus8.match), (i == 0) ? 1 : 0);
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          check("t3_gap_busy", 32'(bus8.busy), 1);
          check("t3_gap_match", 32'(bus8.match), 0);
        end
      end
    end
    check("t3_done",  32'(bus8.done), 1);
    check("t3_count", 32'(bus8.match_count), 1);
    tick();

    // 1111 over 255 ones: 252 matches, CNT_W=4 instance saturates at 15
    do_start(4'b1111, 8'd255);
    for (int i = 1; i <= 255; i++) begin
      send_bit(1'b1);
      if (i == 3)   check("t4_no_match3", 32'(bus8.match), 0);
      if (i == 4)   check("t4_match4", 32'(bus8.match), 1);
      if (i == 18)  check("t4_cnt4_at18", 32'(bus4.match_count), 15);
      if (i == 19)  check("t4_cnt4_sat", 32'(bus4.match_count), 15);
      if (i == 254) check("t4_not_done", 32'(bus8.done), 0);
    end
    check("t4_done",   32'(bus8.done), 1);
    check("t4_count8", 32'(bus8.match_count), 252);
    check("t4_count4", 32'(bus4.match_count), 15);
    check("t4_bits",   32'(bus8.bits_seen), 255);
    tick();

    // Zero-length run: done right after start, never busy
    do_start(4'b1001, 8'd0);
    check("t5_done",  32'(bus8.done), 1);
    check("t5_busy",  32'(bus8.busy), 0);
    check("t5_count", 32'(bus8.match_count), 0);
    check("t5_bits",  32'(bus8.bits_seen), 0);
    tick();
    check("t5_done_one", 32'(bus8.done), 0);

    // Start during RUN is ignored: length 4 still governs
    do_start(4'b1001, 8'd4);
    send_bit(1'b1);
    do_start(4'b0110, 8'd2);
    check("t5_ign_busy", 32'(bus8.busy), 1);
    send_bit(1'b0);
    check("t5_ign_done2", 32'(bus8.done), 0);
    check("t5_ign_bits2", 32'(bus8.bits_seen), 2);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t5_ign_match", 32'(bus8.match), 1);
    check("t5_ign_done",  32'(bus8.done), 1);
    check("t5_ign_count", 32'(bus8.match_count), 1);
    tick();

    // Reset mid-run after two bits, then a fresh run
    do_start(4'b1001, 8'd7);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b0;
    #1;
    check("t6_rst_busy",  32'(bus8.busy), 0);
    check("t6_rst_bits",  32'(bus8.bits_seen), 0);
    check("t6_rst_done",  32'(bus8.done), 0);
    check("t6_rst_match", 32'(bus8.match), 0);
    check("t6_rst_count", 32'(bus8.match_count), 0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_no_done", 32'(bus8.done), 0);
    check("t6_idle",    32'(bus8.busy), 0);
    do_start(4'b1001, 8'd5);
    s6_bits = 5'b01001;
    s6_exp  = 5'b00001;
    for (int i = 4; i >= 0; i--) begin
      send_bit(s6_bits[i]);
      check("t6_match", 32'(bus8.match), 32'(s6_exp[i]));
    end
    check("t6_done",  32'(bus8.done), 1);
    check("t6_count", 32'(bus8.match_count), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
